// File: rtl/prng_sched_pkg.sv
// prng_sched_pkg: shared types and constants for the PRNG sequencer/arbiter.
package prng_sched_pkg;

    typedef enum logic [1:0] {INIT, WARMUP, SERVE, RESEED} state_t;

    localparam logic [31:0] DEFAULT_SEED = 32'h2545_F491;

    function automatic int wcnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    logic [$clog2(N)-1:0] j;

    // Walk from farthest to nearest so the closest requester after last wins.
    always_comb begin
        gnt = '0;
        idx = last;
        j = '0;
        for (int i = N; i >= 1; i--) begin
            j = $clog2(N)'((int'(last) + i) % N);
            if (en && req[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/prng_scheduler.sv
// prng_scheduler: seeds and warms up the xorshift PRNG, reseeds on entropy
// events and hands out one distinct word per round-robin grant.
module prng_scheduler
    import prng_sched_pkg::*;
#(
    parameter int          NUM_REQ       = 4,
    parameter logic [31:0] DEFAULT_SEED  = prng_sched_pkg::DEFAULT_SEED,
    parameter int          WARMUP_CYCLES = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [31:0]        rnd_o,
    input  logic               entropy_i,
    output logic               ready_o,
    output logic [31:0]        seed_o,
    output logic               collect_seed_o,
    input  logic [31:0]        prn_i
);

    localparam int LW = $clog2(NUM_REQ);
    localparam int WW = wcnt_width(WARMUP_CYCLES);

    state_t             state, state_nx;
    logic [WW-1:0]      wcnt;
    logic [31:0]        ent_cnt, mix;
    logic               pend, pend_eff, warm_done;
    logic [LW-1:0]      last, arb_idx;
    logic [NUM_REQ-1:0] arb_gnt;

    // A pulse this cycle counts as pending so it beats any grant decided now.
    assign pend_eff  = pend | entropy_i;
    assign warm_done = wcnt == WW'(WARMUP_CYCLES - 1);
    assign mix       = ent_cnt ^ prn_i;
    assign ready_o   = state == SERVE;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req  (req_i),
        .last (last),
        .en   (state == SERVE && !pend_eff),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    always_comb begin
        state_nx = state;
        collect_seed_o = 1'b0;
        seed_o = '0;
        case (state)
            INIT: begin
                state_nx = WARMUP;
                collect_seed_o = 1'b1;
                seed_o = DEFAULT_SEED;
            end
            WARMUP: if (warm_done) state_nx = SERVE;
            SERVE: if (pend_eff) state_nx = RESEED;
            RESEED: begin
                state_nx = WARMUP;
                collect_seed_o = 1'b1;
                seed_o = mix == '0 ? DEFAULT_SEED : mix;
            end
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= INIT;
            wcnt <= '0;
            ent_cnt <= '0;
            pend <= 1'b0;
            last <= LW'(NUM_REQ - 1);
            gnt_o <= '0;
            rnd_o <= '0;
        end else begin
            state <= state_nx;
            wcnt <= (state == WARMUP && !warm_done) ? wcnt + 1'b1 : '0;
            ent_cnt <= ent_cnt + 32'd1;
            pend <= state != SERVE && pend_eff;
            last <= |arb_gnt ? arb_idx : last;
            gnt_o <= arb_gnt;
            rnd_o <= |arb_gnt ? prn_i : '0;
        end
    end

endmodule

// File: tb/tb_prng_scheduler.sv
// tb_prng_scheduler: scenario tasks checked against expectations derived from
// the sequencing rules and a round-robin pick model.
module tb_prng_scheduler;

    localparam int          N     = 4;
    localparam int          LW    = $clog2(N);
    localparam int          WU    = 8;
    localparam logic [31:0] DSEED = 32'h2545_F491;
    localparam int          S1    = WU + 2;
    localparam int          R1    = S1 + 1;
    localparam int          S2    = R1 + WU + 1;
    localparam int          G     = S2 + 1;

    logic         clk_i = 1'b0, reset_i = 1'b1, entropy_i = 1'b0;
    logic         collect_seed_o, ready_o;
    logic [N-1:0] req_i = '0, gnt_o;
    logic [31:0]  rnd_o, seed_o, prn_i = '0;
    int           cyc, n_cmp, n_bad;

    always #5 clk_i = ~clk_i;

    prng_scheduler #(.NUM_REQ(N), .DEFAULT_SEED(DSEED), .WARMUP_CYCLES(WU)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .rnd_o          (rnd_o),
        .entropy_i      (entropy_i),
        .ready_o        (ready_o),
        .seed_o         (seed_o),
        .collect_seed_o (collect_seed_o),
        .prn_i          (prn_i)
    );

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[LW'((last + k) % N)]) return (last + k) % N;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // Cycle 1 is the first cycle after release, with the entropy counter at 0.
    task automatic do_reset();
        reset_i = 1'b1;
        entropy_i = 1'b0;
        req_i = '0;
        prn_i = '0;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        cyc = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (collect_seed_o !== 1'b1 || seed_o !== DSEED) begin
            n_bad++;
            $display("FAIL reset_seed: collect=%b seed=%h expected collect=1 seed=%h", collect_seed_o, seed_o, DSEED);
        end
        n_cmp++;
        if (ready_o !== 1'b0 || gnt_o !== '0 || rnd_o !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: ready=%b gnt=%b rnd=%h expected all zero", ready_o, gnt_o, rnd_o);
        end
        req_i = '1;
        while (cyc < S1) begin
            tick();
            prn_i = $urandom;
            #1;
            if (cyc < S1) begin
                n_cmp++;
                if ({ready_o, gnt_o, collect_seed_o, seed_o} !== '0) begin
                    n_bad++;
                    $display("FAIL warmup_idle c=%0d: ready=%b gnt=%b collect=%b seed=%h expected all zero", cyc, ready_o, gnt_o, collect_seed_o, seed_o);
                end
            end
        end
        n_cmp++;
        if (ready_o !== 1'b1 || gnt_o !== '0) begin
            n_bad++;
            $display("FAIL serve_entry c=%0d: ready=%b gnt=%b expected ready=1 gnt=0", cyc, ready_o, gnt_o);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] e;
        logic [31:0]  prev;
        prn_i = 32'(cyc);
        prev = prn_i;
        for (int k = 0; k < 3 * N; k++) begin
            tick();
            e = '0;
            e[LW'(k % N)] = 1'b1;
            n_cmp++;
            if (gnt_o !== e || rnd_o !== prev) begin
                n_bad++;
                $display("FAIL rr_seq k=%0d: gnt=%b rnd=%h expected gnt=%b rnd=%h", k, gnt_o, rnd_o, e, prev);
            end
            prn_i = 32'(cyc);
            prev = prn_i;
        end
    endtask

    task automatic test_random_rr();
        logic [N-1:0] pending, eg;
        logic [31:0]  er;
        int           last_m, w;
        pending = req_i;
        last_m = N - 1;
        for (int i = 0; i < 300; i++) begin
            w = rr_pick(pending, last_m);
            eg = '0;
            er = '0;
            if (w >= 0) begin
                eg[LW'(w)] = 1'b1;
                er = prn_i;
                last_m = w;
            end
            tick();
            n_cmp++;
            if (gnt_o !== eg || rnd_o !== er) begin
                n_bad++;
                $display("FAIL rr_random i=%0d: gnt=%b rnd=%h expected gnt=%b rnd=%h", i, gnt_o, rnd_o, eg, er);
            end
            pending &= ~eg;
            if ($urandom_range(0, 2) != 0) pending |= N'($urandom);
            req_i = pending;
            prn_i = $urandom;
        end
    endtask

    task automatic test_entropy_and_req();
        logic [31:0] p;
        req_i = '0;
        tick();
        tick();
        entropy_i = 1'b1;
        req_i = N'(2);
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL ent_req_serve: ready=%b expected 1", ready_o);
        end
        tick();
        entropy_i = 1'b0;
        n_cmp++;
        if (collect_seed_o !== 1'b1 || gnt_o !== '0) begin
            n_bad++;
            $display("FAIL ent_req_reseed_first: collect=%b gnt=%b expected collect=1 gnt=0", collect_seed_o, gnt_o);
        end
        repeat (WU) begin
            tick();
            n_cmp++;
            if ({ready_o, gnt_o} !== '0) begin
                n_bad++;
                $display("FAIL ent_req_warmup: ready=%b gnt=%b expected 0", ready_o, gnt_o);
            end
        end
        tick();
        p = $urandom;
        prn_i = p;
        n_cmp++;
        if (ready_o !== 1'b1 || gnt_o !== '0) begin
            n_bad++;
            $display("FAIL ent_req_reentry: ready=%b gnt=%b expected ready=1 gnt=0", ready_o, gnt_o);
        end
        tick();
        n_cmp++;
        if (gnt_o !== N'(2) || rnd_o !== p) begin
            n_bad++;
            $display("FAIL ent_req_grant: gnt=%b rnd=%h expected gnt=%b rnd=%h", gnt_o, rnd_o, N'(2), p);
        end
        req_i = '0;
    endtask

    // Boot sequence from cycle 1 with entropy at cycles 3 and 6: one reseed
    // right after the first SERVE cycle, a second warm-up, then one grant.
    task automatic seq_reseed(input logic zero, input logic [N-1:0] req);
        logic [31:0]  prev, exp_seed;
        logic [N-1:0] exp_gnt;
        int           w;
        req_i = req;
        prev = '0;
        w = rr_pick(req, N - 1);
        for (int c = 1; c <= G; c++) begin
            if (c > 1) tick();
            entropy_i = (cyc == 3 || cyc == 6);
            prn_i = (zero && cyc == R1) ? 32'(cyc - 1) : ($urandom | 32'h8000_0000);
            #1;
            exp_seed = cyc == 1 ? DSEED : cyc == R1 ? (zero ? DSEED : prn_i ^ 32'(cyc - 1)) : '0;
            exp_gnt = '0;
            if (cyc == G) exp_gnt[LW'(w)] = 1'b1;
            n_cmp++;
            if (collect_seed_o !== (cyc == 1 || cyc == R1) || seed_o !== exp_seed) begin
                n_bad++;
                $display("FAIL seq_seed c=%0d: collect=%b seed=%h expected collect=%b seed=%h", cyc, collect_seed_o, seed_o, (cyc == 1 || cyc == R1), exp_seed);
            end
            n_cmp++;
            if (ready_o !== (cyc == S1 || cyc >= S2) || gnt_o !== exp_gnt) begin
                n_bad++;
                $display("FAIL seq_grant c=%0d: ready=%b gnt=%b expected ready=%b gnt=%b", cyc, ready_o, gnt_o, (cyc == S1 || cyc >= S2), exp_gnt);
            end
            if (cyc == G) begin
                n_cmp++;
                if (rnd_o !== prev) begin
                    n_bad++;
                    $display("FAIL seq_rnd: rnd=%h expected %h", rnd_o, prev);
                end
            end
            prev = prn_i;
        end
        req_i = '0;
        entropy_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_i = N'(1);
        #1 reset_i = 1'b1;
        #1;
        n_cmp++;
        if ({gnt_o, ready_o} !== '0 || collect_seed_o !== 1'b1 || seed_o !== DSEED) begin
            n_bad++;
            $display("FAIL async_reset: gnt=%b ready=%b collect=%b seed=%h expected 0 0 1 %h", gnt_o, ready_o, collect_seed_o, seed_o, DSEED);
        end
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        cyc = 1;
        seq_reseed(1'b0, N'(1));
    endtask

    task automatic test_entropy_warmup();
        do_reset();
        seq_reseed(1'b0, '1);
    endtask

    task automatic test_zero_seed();
        do_reset();
        seq_reseed(1'b1, '1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        test_reset();
        test_round_robin();
        test_random_rr();
        test_entropy_and_req();
        test_reset_mid();
        test_entropy_warmup();
        test_zero_seed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
